aes_key_schedule_seq: RTL and testbench

Iterative AES-128 key expansion stage that sits directly upstream of encrypt_round and drives its round_key input. It accepts one 128-bit cipher key through a valid/ready handshake. It then streams round keys 0..NUM_ROUNDS, one per accepted output beat, through a second valid/ready handshake. Each next key is computed on the fly from the current key, so there is no 11-entry key store.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_sub_word.sv | 11 +
 rtl/aes_key_schedule_seq.sv | 59 +++++
 tb/tb_aes_key_schedule_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-box and key-schedule FSM states
package aes_pkg;
  localparam int AES_KEY_W = 128;
  localparam int AES_WORD_W = 32;
  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  typedef enum logic {KS_IDLE, KS_EMIT} ks_state_e;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*(255 - int'(x)) +: 8];
  endfunction
endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: byte-wise S-box substitution of one 32-bit word
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [AES_WORD_W-1:0] word,
  output logic [AES_WORD_W-1:0] sub
);
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign sub[8*i +: 8] = sbox(word[8*i +: 8]);
  end
endmodule

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: iterative AES-128 key expansion streaming round keys 0..NUM_ROUNDS
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [AES_KEY_W-1:0] cipher_key,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [AES_KEY_W-1:0] rk_data,
  output logic [3:0]           rk_index,
  output logic                 rk_last,
  output logic                 busy
);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
  ks_state_e state, state_nx;
  logic [AES_KEY_W-1:0] key_reg;
  logic [3:0] round, rcon_idx;
  logic [AES_WORD_W-1:0] sw, t, n0, n1, n2, n3;
  logic adv, fin;
  assign adv = rk_valid && rk_ready;
  assign fin = adv && round == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= KS_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == KS_IDLE ? (key_valid ? KS_EMIT : KS_IDLE) : (fin ? KS_IDLE : KS_EMIT);
  always_comb begin
    key_ready = state == KS_IDLE;
    rk_valid = state == KS_EMIT;
    busy = rk_valid;
    rk_data = rk_valid ? key_reg : '0;
    rk_index = rk_valid ? round : 4'd0;
    rk_last = rk_valid && round == LAST;
  end
  // rcon_idx stays inside 1..10; its value is unused once round reaches LAST
  assign rcon_idx = round < LAST ? round + 4'd1 : 4'd1;
  aes_sub_word u_sub (.word({key_reg[23:0], key_reg[31:24]}), .sub(sw));
  assign t = sw ^ {RCON[rcon_idx], 24'h0};
  assign n0 = key_reg[127:96] ^ t;
  assign n1 = key_reg[95:64] ^ n0;
  assign n2 = key_reg[63:32] ^ n1;
  assign n3 = key_reg[31:0] ^ n2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_reg <= '0;
      round <= 4'd0;
    end else if (key_valid && key_ready) begin
      key_reg <= cipher_key;
      round <= 4'd0;
    end else if (adv && round != LAST) begin
      key_reg <= {n0, n1, n2, n3};
      round <= round + 4'd1;
    end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb_aes_key_schedule_seq: scoreboard bench against a FIPS-197 KeyExpansion model
module tb_aes_key_schedule_seq;
  typedef struct {logic [127:0] d; logic [3:0] i; logic l;} beat_t;
  localparam logic [127:0] KA1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KSEQ = 128'h000102030405060708090a0b0c0d0e0f;
  logic clk, rst_n, key_valid, key_ready, rk_valid, rk_ready, rk_last, busy;
  logic [127:0] cipher_key, rk_data;
  logic [3:0] rk_index;
  logic kv4, kr4, rv4, rl4, busy4;
  logic rr4 = 1'b1;
  logic [127:0] ck4, rd4;
  logic [3:0] ri4;
  beat_t sb[$], sb4[$];
  beat_t e, e4;
  logic [7:0] sref [256];
  int tests, fails, cyc, acc_cyc, last_cyc;
  bit bp, full_rate, b2b, in_stream;

  aes_key_schedule_seq dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .cipher_key(cipher_key), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_index(rk_index), .rk_last(rk_last), .busy(busy));
  aes_key_schedule_seq #(.NUM_ROUNDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .key_valid(kv4), .key_ready(kr4),
    .cipher_key(ck4), .rk_valid(rv4), .rk_ready(rr4), .rk_data(rd4),
    .rk_index(ri4), .rk_last(rl4), .busy(busy4));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 rk_ready = bp ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] sbox_gf(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int c = 1; c < 256; c++) if (x != 0 && gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] rkey(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4*r + 4; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sref[tmp[23:16]], sref[tmp[15:8]], sref[tmp[7:0]], sref[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic push(input logic [127:0] k, input int nr, input bit four);
    beat_t b;
    for (int i = 0; i <= nr; i++) begin
      b.d = rkey(k, i);
      b.i = 4'(i);
      b.l = i == nr;
      if (four) sb4.push_back(b);
      else sb.push_back(b);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("key_ready wait", key_ready, 1);
  endtask

  task automatic send(input logic [127:0] k);
    push(k, 10, 0);
    cipher_key = k;
    key_valid = 1;
    wait_ready();
    @(posedge clk);
    #1 key_valid = 0;
  endtask

  task automatic drain(input bit four);
    int n = 0;
    while ((four ? sb4.size() : sb.size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", four ? sb4.size() : sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) in_stream = 0;
    else begin
      cyc++;
      chk("rk_valid", rk_valid, in_stream);
      chk("busy", busy, in_stream);
      chk("key_ready", key_ready, !in_stream);
      if (rk_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra beat: rk_index %0d with nothing expected", rk_index);
        end else begin
          chk("rk_data", rk_data, sb[0].d);
          chk("rk_index", rk_index, sb[0].i);
          chk("rk_last", rk_last, sb[0].l);
          if (rk_ready) begin
            e = sb.pop_front();
            if (full_rate) chk("beat cycle", cyc, acc_cyc + 1 + int'(e.i));
            if (e.l) begin
              in_stream = 0;
              last_cyc = cyc;
            end
          end
        end
      end else begin
        chk("idle rk_index", rk_index, 0);
        chk("idle rk_last", rk_last, 0);
      end
      if (key_valid && key_ready) begin
        in_stream = 1;
        acc_cyc = cyc;
        if (b2b) chk("accept cycle", cyc, last_cyc + 1);
      end
    end
  end

  always @(negedge clk)
    if (rst_n && rv4) begin
      if (sb4.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra beat4: rk_index %0d with nothing expected", ri4);
      end else begin
        chk("rk_data4", rd4, sb4[0].d);
        chk("rk_index4", ri4, sb4[0].i);
        chk("rk_last4", rl4, sb4[0].l);
        e4 = sb4.pop_front();
      end
    end

  initial begin
    int n;
    for (int x = 0; x < 256; x++) sref[x] = sbox_gf(8'(x));
    rst_n = 1;
    key_valid = 0;
    cipher_key = '0;
    kv4 = 0;
    ck4 = '0;
    #2 rst_n = 0;
    #1;
    chk("reset rk_valid", rk_valid, 0);
    chk("reset rk_data", rk_data, 0);
    chk("reset rk_index", rk_index, 0);
    chk("reset rk_last", rk_last, 0);
    chk("reset busy", busy, 0);
    chk("reset key_ready", key_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    full_rate = 1;
    send(KA1);
    drain(0);
    send(KSEQ);
    drain(0);
    full_rate = 0;
    bp = 1;
    send(KA1);
    drain(0);
    repeat (3) begin
      send({$urandom, $urandom, $urandom, $urandom});
      drain(0);
    end
    bp = 0;
    full_rate = 1;
    push(KSEQ, 10, 0);
    push(KA1, 10, 0);
    key_valid = 1;
    cipher_key = KSEQ;
    wait_ready();
    @(posedge clk);
    #1 cipher_key = KA1;
    b2b = 1;
    wait_ready();
    @(posedge clk);
    #1 key_valid = 0;
    b2b = 0;
    drain(0);
    send(KA1);
    n = 0;
    while (rk_index !== 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach index 5", rk_index, 5);
    #2 rst_n = 0;
    #1;
    chk("abort rk_valid", rk_valid, 0);
    chk("abort rk_index", rk_index, 0);
    chk("abort rk_last", rk_last, 0);
    chk("abort rk_data", rk_data, 0);
    chk("abort key_ready", key_ready, 1);
    chk("abort busy", busy, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    send(KA1);
    drain(0);
    push(KA1, 4, 1);
    ck4 = KA1;
    kv4 = 1;
    n = 0;
    @(negedge clk);
    while (!kr4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 kv4 = 0;
    drain(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
